// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one imem request at a time,
// and hands instructions to decode through an output register plus a one-entry skid.
// Latency: imem data accepted at edge N is on if_* after edge N; stall parks one fetch in skid.
module fetch_ctrl #(
    parameter int                 ADDR_W   = 6,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0,
    parameter int                 DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              br_valid,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              imem_ready,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              ce,
    output logic [ADDR_W-1:0] pc,
    output logic              imem_req,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_inst,
    output logic [ADDR_W-1:0] if_pc
);

    typedef enum logic [1:0] {
        S_OFF   = 2'd0,
        S_ISSUE = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t              state;
    // The skid entry is occupied exactly when the FSM is in S_FULL, so no
    // separate valid bit is kept for it.
    logic [DATA_W-1:0]   skid_inst;
    logic [ADDR_W-1:0]   skid_pc;
    // Redirect that arrived while a request was still in flight; applied
    // once the stale response comes back.
    logic                pend;
    logic [ADDR_W-1:0]   pend_pc;

    logic                consume;
    logic                slot_free;

    // Decode takes the output register this cycle / the register can take new data.
    always_comb begin
        consume   = if_valid && !stall;
        slot_free = !if_valid || consume;
    end

    // Request level is decoded straight from the state register.
    assign imem_req = (state == S_ISSUE);

    // Fetch FSM, PC, output register, skid entry and pending-redirect tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_OFF;
            ce        <= 1'b0;
            pc        <= RESET_PC;
            if_valid  <= 1'b0;
            if_inst   <= '0;
            if_pc     <= '0;
            skid_inst <= '0;
            skid_pc   <= '0;
            pend      <= 1'b0;
            pend_pc   <= '0;
        end else begin
            case (state)
                S_OFF: begin
                    // Redirects are ignored until fetching is enabled.
                    state <= S_ISSUE;
                    ce    <= 1'b1;
                end

                S_ISSUE: begin
                    if (br_valid) begin
                        // Redirect wins over stall and ready; flush everything downstream.
                        if_valid <= 1'b0;
                        if (imem_ready) begin
                            // Response for the old path is dropped on the floor.
                            pc   <= br_target;
                            pend <= 1'b0;
                        end else begin
                            // Request still in flight: keep pc stable for memory,
                            // remember where to go once it returns.
                            pend    <= 1'b1;
                            pend_pc <= br_target;
                        end
                    end else if (imem_ready && pend) begin
                        // Stale response for a redirected request: discard it.
                        pc   <= pend_pc;
                        pend <= 1'b0;
                        if (consume) begin
                            if_valid <= 1'b0;
                        end
                    end else if (imem_ready && slot_free) begin
                        if_valid <= 1'b1;
                        if_inst  <= imem_rdata;
                        if_pc    <= pc;
                        pc       <= pc + PC_ONE;
                    end else if (imem_ready) begin
                        // Decode is stalled: park the completed fetch and stop issuing.
                        skid_inst <= imem_rdata;
                        skid_pc   <= pc;
                        pc        <= pc + PC_ONE;
                        state     <= S_FULL;
                    end else if (consume) begin
                        if_valid <= 1'b0;
                    end
                end

                S_FULL: begin
                    if (br_valid) begin
                        if_valid <= 1'b0;
                        pc       <= br_target;
                        state    <= S_ISSUE;
                    end else if (consume) begin
                        // Drain the skid into the output register and resume fetching.
                        if_valid <= 1'b1;
                        if_inst  <= skid_inst;
                        if_pc    <= skid_pc;
                        state    <= S_ISSUE;
                    end
                end

                default: begin
                    state <= S_OFF;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: the bench acts as instruction memory and
// decode; expected fetch addresses are queued as stimulus is applied and
// popped whenever decode consumes an instruction.
module tb_fetch_ctrl;

    localparam int AW = 6;
    localparam int DW = 32;

    logic          clk;
    logic          rst;
    logic          stall;
    logic          br_valid;
    logic [AW-1:0] br_target;
    logic          rdy_en;
    logic          imem_ready;
    logic [DW-1:0] imem_rdata;
    logic          ce;
    logic [AW-1:0] pc;
    logic          imem_req;
    logic          if_valid;
    logic [DW-1:0] if_inst;
    logic [AW-1:0] if_pc;

    int checks = 0;
    int errors = 0;
    logic [AW-1:0] exp_q[$];

    fetch_ctrl #(.ADDR_W(AW), .RESET_PC(6'd0), .DATA_W(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .br_valid   (br_valid),
        .br_target  (br_target),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .ce         (ce),
        .pc         (pc),
        .imem_req   (imem_req),
        .if_valid   (if_valid),
        .if_inst    (if_inst),
        .if_pc      (if_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return {16'hC0DE, 2'b00, a, 2'b11, ~a};
    endfunction

    // Memory model: answers only while a request is raised.
    assign imem_ready = rdy_en & imem_req;
    assign imem_rdata = mem_word(pc);

    task automatic do_reset();
        rst       = 1'b1;
        stall     = 1'b0;
        br_valid  = 1'b0;
        br_target = '0;
        rdy_en    = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [AW-1:0] e;
        rst = 1'b1; stall = 1'b0; br_valid = 1'b0; br_target = '0; rdy_en = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (ce !== 1'b0 || imem_req !== 1'b0 || if_valid !== 1'b0 || pc !== 6'd0 ||
            if_pc !== 6'd0 || if_inst !== 32'd0) begin
            errors++;
            $display("FAIL reset_values: ce=%b req=%b vld=%b pc=%0h if_pc=%0h inst=%0h, required 0 0 0 0 0 0",
                     ce, imem_req, if_valid, pc, if_pc, if_inst);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (ce !== 1'b0) begin
            errors++;
            $display("FAIL ce_off_after_release: ce=%b required 0", ce);
        end
        @(negedge clk);
        checks++;
        if (ce !== 1'b1 || imem_req !== 1'b1 || pc !== 6'd0 || if_valid !== 1'b0) begin
            errors++;
            $display("FAIL first_request: ce=%b req=%b pc=%0h vld=%b, required 1 1 0 0",
                     ce, imem_req, pc, if_valid);
        end
        e = '0;
    endtask

    task automatic test_stream_wrap();
        int gaps = 0;
        bit started = 0;
        logic [AW-1:0] e;
        do_reset();
        for (int i = 0; i < 70; i++) exp_q.push_back(AW'(i));
        rdy_en = 1'b1;
        for (int c = 0; c < 200 && exp_q.size() > 0; c++) begin
            if (started && !if_valid) gaps++;
            if (if_valid && !stall) begin
                started = 1;
                e = exp_q.pop_front();
                checks++;
                if (if_pc !== e || if_inst !== mem_word(e)) begin
                    errors++;
                    $display("FAIL stream: if_pc=%0h inst=%0h, required %0h %0h", if_pc, if_inst, e, mem_word(e));
                end
            end
            @(negedge clk);
        end
        checks++;
        if (exp_q.size() != 0 || gaps != 0) begin
            errors++;
            $display("FAIL stream_throughput: left=%0d gaps=%0d, required 0 0", exp_q.size(), gaps);
        end
    endtask

    task automatic test_stall();
        logic [AW-1:0] e;
        do_reset();
        for (int i = 0; i < 20; i++) exp_q.push_back(AW'(i));
        rdy_en = 1'b1;
        for (int c = 0; c < 60 && exp_q.size() > 0; c++) begin
            stall = (c >= 10 && c < 13);
            if (c == 11 || c == 12) begin
                checks++;
                if (imem_req !== 1'b0 || if_valid !== 1'b1 || if_pc !== 6'd9) begin
                    errors++;
                    $display("FAIL stall_hold c=%0d: req=%b vld=%b if_pc=%0h, required 0 1 9",
                             c, imem_req, if_valid, if_pc);
                end
            end
            if (if_valid && !stall) begin
                e = exp_q.pop_front();
                checks++;
                if (if_pc !== e || if_inst !== mem_word(e)) begin
                    errors++;
                    $display("FAIL stall_seq: if_pc=%0h inst=%0h, required %0h %0h", if_pc, if_inst, e, mem_word(e));
                end
            end
            @(negedge clk);
        end
        stall = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL stall_timeout: %0d left, required 0", exp_q.size());
        end
    endtask

    // One or two redirects while the request at pc=5 waits for memory.
    task automatic test_redirect_pending(input bit two);
        logic [AW-1:0] e;
        logic [AW-1:0] tgt;
        tgt = two ? 6'h30 : 6'h20;
        do_reset();
        for (int i = 0; i < 5; i++) exp_q.push_back(AW'(i));
        for (int i = 0; i < 3; i++) exp_q.push_back(tgt + AW'(i));
        for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
            br_valid = 1'b0;
            rdy_en   = 1'b1;
            if (c == 5) begin
                br_valid = 1'b1; br_target = two ? 6'h10 : 6'h20; rdy_en = 1'b0;
            end
            if (c == 6) begin
                br_valid = two; br_target = 6'h30; rdy_en = 1'b0;
            end
            if (c == 7 && two) rdy_en = 1'b0;
            if (c == 6) begin
                checks++;
                if (pc !== 6'd5 || imem_req !== 1'b1) begin
                    errors++;
                    $display("FAIL redir_inflight_pc: pc=%0h req=%b, required 5 1", pc, imem_req);
                end
            end
            if (c >= 6 && c <= (two ? 9 : 8)) begin
                checks++;
                if (if_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL redir_gap c=%0d: if_valid=%b required 0", c, if_valid);
                end
            end
            if (c == (two ? 9 : 8)) begin
                checks++;
                if (pc !== tgt) begin
                    errors++;
                    $display("FAIL redir_target: pc=%0h required %0h", pc, tgt);
                end
            end
            if (if_valid && !stall) begin
                e = exp_q.pop_front();
                checks++;
                if (if_pc !== e || if_inst !== mem_word(e)) begin
                    errors++;
                    $display("FAIL redir_seq: if_pc=%0h inst=%0h, required %0h %0h", if_pc, if_inst, e, mem_word(e));
                end
            end
            @(negedge clk);
        end
        br_valid = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL redir_timeout: %0d left, required 0", exp_q.size());
        end
    endtask

    // Redirect coinciding with ready while stalled, then a redirect out of FULL across the wrap.
    task automatic test_redirect_flush();
        logic [AW-1:0] e;
        logic [AW-1:0] seq[10] = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd8, 6'd9, 6'd10, 6'h3F, 6'd0, 6'd1};
        do_reset();
        foreach (seq[i]) exp_q.push_back(seq[i]);
        rdy_en = 1'b1;
        for (int c = 0; c < 50 && exp_q.size() > 0; c++) begin
            br_valid = 1'b0;
            stall    = (c == 5) || (c == 10) || (c == 11);
            if (c == 5)  begin br_valid = 1'b1; br_target = 6'h08; end
            if (c == 11) begin br_valid = 1'b1; br_target = 6'h3F; end
            if (c == 6) begin
                checks++;
                if (if_valid !== 1'b0 || pc !== 6'h08 || imem_req !== 1'b1) begin
                    errors++;
                    $display("FAIL flush_same_cycle: vld=%b pc=%0h req=%b, required 0 8 1", if_valid, pc, imem_req);
                end
            end
            if (c == 11) begin
                checks++;
                if (imem_req !== 1'b0 || if_valid !== 1'b1 || if_pc !== 6'd11) begin
                    errors++;
                    $display("FAIL flush_full_pre: req=%b vld=%b if_pc=%0h, required 0 1 b", imem_req, if_valid, if_pc);
                end
            end
            if (c == 12) begin
                checks++;
                if (if_valid !== 1'b0 || pc !== 6'h3F || imem_req !== 1'b1) begin
                    errors++;
                    $display("FAIL flush_full: vld=%b pc=%0h req=%b, required 0 3f 1", if_valid, pc, imem_req);
                end
            end
            if (if_valid && !stall) begin
                e = exp_q.pop_front();
                checks++;
                if (if_pc !== e || if_inst !== mem_word(e)) begin
                    errors++;
                    $display("FAIL flush_seq: if_pc=%0h inst=%0h, required %0h %0h", if_pc, if_inst, e, mem_word(e));
                end
            end
            @(negedge clk);
        end
        br_valid = 1'b0;
        stall    = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL flush_timeout: %0d left, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid_request();
        logic [AW-1:0] e;
        do_reset();
        exp_q.push_back(6'd0);
        exp_q.push_back(6'd1);
        for (int c = 0; c < 5; c++) begin
            rdy_en = (c < 3);
            stall  = (c >= 3);
            if (if_valid && !stall) begin
                e = exp_q.pop_front();
                checks++;
                if (if_pc !== e) begin
                    errors++;
                    $display("FAIL rstmid_pre_seq: if_pc=%0h required %0h", if_pc, e);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (if_valid !== 1'b1 || imem_req !== 1'b1 || if_pc !== 6'd2) begin
            errors++;
            $display("FAIL rstmid_precond: vld=%b req=%b if_pc=%0h, required 1 1 2", if_valid, imem_req, if_pc);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (if_valid !== 1'b0 || ce !== 1'b0 || imem_req !== 1'b0 || pc !== 6'd0 || if_pc !== 6'd0) begin
            errors++;
            $display("FAIL rstmid_async: vld=%b ce=%b req=%b pc=%0h if_pc=%0h, required 0 0 0 0 0",
                     if_valid, ce, imem_req, pc, if_pc);
        end
        stall  = 1'b0;
        rdy_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        exp_q.delete();
        for (int i = 0; i < 3; i++) exp_q.push_back(AW'(i));
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
            if (if_valid && !stall) begin
                e = exp_q.pop_front();
                checks++;
                if (if_pc !== e || if_inst !== mem_word(e)) begin
                    errors++;
                    $display("FAIL rstmid_restart: if_pc=%0h inst=%0h, required %0h %0h", if_pc, if_inst, e, mem_word(e));
                end
            end
            @(negedge clk);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL rstmid_timeout: %0d left, required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_stream_wrap();
        test_stall();
        test_redirect_pending(1'b0);
        test_redirect_pending(1'b1);
        test_redirect_flush();
        test_reset_mid_request();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
